// File: rtl/store_buffer_q_if.sv
// Store-buffer boundary bundle: the enqueue port from the LSQ and the
// write port toward the data cache.
interface store_buffer_q_if #(
  parameter int ROB_ID_SIZE = 4
);
  logic                   enq_valid;
  logic [ROB_ID_SIZE-1:0] enq_rob_id;
  logic [31:0]            enq_addr;
  logic [3:0]             enq_wmask;
  logic [31:0]            enq_wdata;
  logic                   enq_ready;

  logic [31:0]            dmem_addr;
  logic [3:0]             dmem_wmask;
  logic [31:0]            dmem_wdata;
  logic                   dmem_resp;

  modport master (
    output enq_valid, enq_rob_id, enq_addr, enq_wmask, enq_wdata,
    input  enq_ready,
    input  dmem_addr, dmem_wmask, dmem_wdata,
    output dmem_resp
  );

  modport slave (
    input  enq_valid, enq_rob_id, enq_addr, enq_wmask, enq_wdata,
    output enq_ready,
    output dmem_addr, dmem_wmask, dmem_wdata,
    input  dmem_resp
  );
endinterface

// File: rtl/store_buffer_q.sv
// Age-ordered store buffer: holds speculative stores, commits them in ROB
// order, drains committed stores one at a time and forwards to younger loads.
module store_buffer_q #(
  parameter int DEPTH       = 8,
  parameter int ROB_ID_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  store_buffer_q_if.slave        sb,
  input  logic                   commit_valid,
  input  logic [ROB_ID_SIZE-1:0] commit_rob_id,
  input  logic                   flush,
  input  logic [31:0]            ld_addr,
  input  logic [3:0]             ld_rmask,
  output logic                   fwd_hit,
  output logic [31:0]            fwd_data,
  output logic                   fwd_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   commit_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {SB_IDLE, SB_WAIT} state_t;

  state_t state, state_next;

  logic [ROB_ID_SIZE-1:0] rob_q   [DEPTH];
  logic [29:0]            addr_q  [DEPTH];
  logic [3:0]             wmask_q [DEPTH];
  logic [31:0]            wdata_q [DEPTH];

  logic [PW-1:0] head, cmt, tail, cmt_next;
  logic [CW-1:0] n_total, n_cmt, n_cmt_next;
  logic          enq_fire, commit_fire, pop, issue;
  logic          unused_bits;

  assign unused_bits  = ^{sb.enq_addr[1:0], ld_addr[1:0]};

  assign sb.enq_ready = n_total < CW'(DEPTH);
  assign count        = n_total;
  assign commit_empty = (n_cmt == '0);

  assign enq_fire    = sb.enq_valid && sb.enq_ready && !flush;
  assign commit_fire = commit_valid && (n_cmt < n_total) && (commit_rob_id == rob_q[cmt]);
  assign pop         = (state == SB_WAIT) && sb.dmem_resp;
  assign issue       = (state == SB_IDLE) && (n_cmt != '0);

  // A same-cycle commit lands before the flush, so the committed entry survives it.
  always_comb begin
    cmt_next   = cmt + PW'(commit_fire);
    n_cmt_next = n_cmt + CW'(commit_fire) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      cmt     <= '0;
      tail    <= '0;
      n_total <= '0;
      n_cmt   <= '0;
    end else begin
      head  <= head + PW'(pop);
      cmt   <= cmt_next;
      n_cmt <= n_cmt_next;
      if (flush) begin
        tail    <= cmt_next;
        n_total <= n_cmt_next;
      end else begin
        tail    <= tail + PW'(enq_fire);
        n_total <= n_total + CW'(enq_fire) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      rob_q[tail]   <= sb.enq_rob_id;
      addr_q[tail]  <= sb.enq_addr[31:2];
      wmask_q[tail] <= sb.enq_wmask;
      wdata_q[tail] <= sb.enq_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SB_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE: if (issue)        state_next = SB_WAIT;
      SB_WAIT: if (sb.dmem_resp) state_next = SB_IDLE;
    endcase
  end

  // Address and data stay on the head entry for the whole transaction; the mask pulses once.
  always_comb begin
    sb.dmem_addr  = '0;
    sb.dmem_wdata = '0;
    sb.dmem_wmask = '0;
    if (n_cmt != '0) begin
      sb.dmem_addr  = {addr_q[head], 2'b00};
      sb.dmem_wdata = wdata_q[head];
    end
    if (issue) sb.dmem_wmask = wmask_q[head];
  end

  // Walk oldest to youngest so the youngest overlapping store is the one kept.
  always_comb begin
    logic          found;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    found     = 1'b0;
    sel       = '0;
    idx       = '0;
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail - PW'(i + 1);
      if ((CW'(i) < n_total) && (addr_q[idx] == ld_addr[31:2]) &&
          ((wmask_q[idx] & ld_rmask) != 4'b0)) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    if (found) begin
      if ((wmask_q[sel] & ld_rmask) == ld_rmask) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q[sel] & {{8{ld_rmask[3]}}, {8{ld_rmask[2]}},
                                   {8{ld_rmask[1]}}, {8{ld_rmask[0]}}};
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_q.sv
// Bench for store_buffer_q: directed scenarios plus randomized traffic, all
// compared each cycle against a queue-based model of the buffer.
module tb_store_buffer_q;
  localparam int DEPTH = 8;
  localparam int RW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic [31:0]   addr;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          commit_valid = 1'b0;
  logic [RW-1:0] commit_rob_id = '0;
  logic          flush = 1'b0;
  logic [31:0]   ld_addr = '0;
  logic [3:0]    ld_rmask = '0;
  logic          fwd_hit, fwd_stall, commit_empty;
  logic [31:0]   fwd_data;
  logic [CW-1:0] count;

  store_buffer_q_if #(.ROB_ID_SIZE(RW)) sb_if ();

  store_buffer_q #(.DEPTH(DEPTH), .ROB_ID_SIZE(RW)) dut (
    .clk(clk), .rst(rst), .sb(sb_if.slave),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .flush(flush),
    .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .count(count), .commit_empty(commit_empty)
  );

  always #5 clk = ~clk;

  entry_t      mq[$];
  int          m_cmt = 0;
  bit          m_busy = 1'b0;
  int          busy_age = 0;
  int          resp_mode = 0;
  int          resp_lat = 1;
  logic [31:0] drained[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the queue contents and the in-flight flag.
  task automatic check_output();
    logic [3:0]  e_wmask, ov;
    logic [31:0] e_addr, e_wdata, e_fdata;
    logic        e_hit, e_stall;
    e_wmask = '0; e_addr = '0; e_wdata = '0; e_fdata = '0; e_hit = 0; e_stall = 0;
    if (m_cmt > 0) begin
      e_addr  = {mq[0].addr[31:2], 2'b00};
      e_wdata = mq[0].wdata;
      if (!m_busy) e_wmask = mq[0].wmask;
    end
    if (ld_rmask != 4'h0) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        ov = mq[j].wmask & ld_rmask;
        if (mq[j].addr[31:2] == ld_addr[31:2] && ov != 4'h0) begin
          if (ov == ld_rmask) begin
            e_hit = 1;
            for (int b = 0; b < 4; b++)
              if (ld_rmask[b]) e_fdata[8*b +: 8] = mq[j].wdata[8*b +: 8];
          end else begin
            e_stall = 1;
          end
          break;
        end
      end
    end
    chk("count",        32'(count),              32'(mq.size()));
    chk("enq_ready",    32'(sb_if.enq_ready),    32'(mq.size() < DEPTH));
    chk("commit_empty", 32'(commit_empty),       32'(m_cmt == 0));
    chk("dmem_wmask",   32'(sb_if.dmem_wmask),   32'(e_wmask));
    chk("dmem_addr",    sb_if.dmem_addr,         e_addr);
    chk("dmem_wdata",   sb_if.dmem_wdata,        e_wdata);
    chk("fwd_hit",      32'(fwd_hit),            32'(e_hit));
    chk("fwd_stall",    32'(fwd_stall),          32'(e_stall));
    chk("fwd_data",     fwd_data,                e_fdata);
    if (sb_if.dmem_wmask !== 4'h0) drained.push_back(sb_if.dmem_addr);
  endtask

  task automatic model_edge();
    bit     ef, cf, pop, issue;
    entry_t e;
    ef    = sb_if.enq_valid && (mq.size() < DEPTH) && !flush;
    cf    = commit_valid && (m_cmt < mq.size()) && (mq[m_cmt].rob == commit_rob_id);
    pop   = m_busy && sb_if.dmem_resp;
    issue = !m_busy && (m_cmt > 0);
    if (cf) m_cmt++;
    if (pop) begin
      void'(mq.pop_front());
      m_cmt--;
      m_busy = 0;
    end else if (issue) begin
      m_busy   = 1;
      busy_age = 0;
    end else if (m_busy) begin
      busy_age++;
    end
    if (flush) while (mq.size() > m_cmt) void'(mq.pop_back());
    if (ef) begin
      e.rob = sb_if.enq_rob_id; e.addr = sb_if.enq_addr;
      e.wmask = sb_if.enq_wmask; e.wdata = sb_if.enq_wdata;
      mq.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input bit ev, input logic [RW-1:0] rob, input logic [31:0] a,
                                input logic [3:0] m, input logic [31:0] d,
                                input bit cv, input logic [RW-1:0] crob, input bit fl);
    sb_if.enq_valid = ev; sb_if.enq_rob_id = rob; sb_if.enq_addr = a;
    sb_if.enq_wmask = m;  sb_if.enq_wdata = d;
    commit_valid = cv; commit_rob_id = crob; flush = fl;
    case (resp_mode)
      1:       sb_if.dmem_resp = m_busy && (busy_age >= resp_lat);
      2:       sb_if.dmem_resp = ($urandom_range(0, 2) == 0);
      3:       sb_if.dmem_resp = 1'b1;
      default: sb_if.dmem_resp = 1'b0;
    endcase
    #1 check_output();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic enq(input logic [RW-1:0] rob, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    apply_stimulus(1, rob, a, m, d, 0, '0, 0);
  endtask

  task automatic commit(input logic [RW-1:0] rob);
    apply_stimulus(0, '0, '0, '0, '0, 1, rob, 0);
  endtask

  task automatic idle();
    apply_stimulus(0, '0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    sb_if.enq_valid = 0; sb_if.enq_rob_id = '0; sb_if.enq_addr = '0;
    sb_if.enq_wmask = '0; sb_if.enq_wdata = '0; sb_if.dmem_resp = 0;
    commit_valid = 0; commit_rob_id = '0; flush = 0;
    mq.delete(); m_cmt = 0; m_busy = 0; busy_age = 0;
    #1 check_output();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain_wait(input string tag);
    int n = 0;
    while ((m_cmt > 0 || m_busy) && n < 100) begin
      idle();
      n++;
    end
    chk(tag, 32'(commit_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [RW-1:0] rob;
    logic [31:0]   a;
    @(negedge clk);
    reset_dut();

    // Three uncommitted stores: nothing may reach dmem.
    drained.delete();
    enq(4'd1, 32'h100, 4'hF, 32'hA0A0_0001);
    enq(4'd2, 32'h104, 4'hF, 32'hA0A0_0002);
    enq(4'd3, 32'h108, 4'hF, 32'hA0A0_0003);
    idle();
    #1;
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_commit_empty", 32'(commit_empty), 32'd1);
    chk("t1_no_issue", 32'(drained.size()), 32'd0);

    // In-order commits (one wrong tag first) with a two-cycle memory.
    resp_mode = 1;
    commit(4'd9);
    commit(4'd1);
    commit(4'd2);
    commit(4'd3);
    drain_wait("t2_drain");
    chk("t2_n", 32'(drained.size()), 32'd3);
    chk("t2_a0", drained[0], 32'h100);
    chk("t2_a1", drained[1], 32'h104);
    chk("t2_a2", drained[2], 32'h108);
    chk("t2_count", 32'(count), 32'd0);

    // Flush keeps only the committed entry and drops a same-cycle enqueue.
    resp_mode = 0;
    drained.delete();
    enq(4'd4, 32'h100, 4'hF, 32'hB0B0_0004);
    enq(4'd5, 32'h104, 4'hF, 32'hB0B0_0005);
    enq(4'd6, 32'h108, 4'hF, 32'hB0B0_0006);
    commit(4'd4);
    apply_stimulus(1, 4'd7, 32'h10C, 4'hF, 32'hB0B0_0007, 0, '0, 1);
    #1;
    chk("t3_count", 32'(count), 32'd1);
    chk("t3_commit_empty", 32'(commit_empty), 32'd0);
    resp_mode = 1;
    drain_wait("t3_drain");
    chk("t3_n", 32'(drained.size()), 32'd1);
    chk("t3_a0", drained[0], 32'h100);
    chk("t3_count_end", 32'(count), 32'd0);

    // Partial-word forwarding.
    enq(4'd8, 32'h200, 4'h3, 32'h0000_BEEF);
    ld_addr = 32'h200; ld_rmask = 4'h3;
    #1;
    chk("t4_hit", 32'(fwd_hit), 32'd1);
    chk("t4_data", fwd_data, 32'h0000_BEEF);
    ld_rmask = 4'hF;
    #1;
    chk("t4_stall", 32'(fwd_stall), 32'd1);
    chk("t4_nohit", 32'(fwd_hit), 32'd0);
    apply_stimulus(0, '0, '0, '0, '0, 0, '0, 1);

    // Youngest store to the same word wins.
    enq(4'd9,  32'h300, 4'hF, 32'h1111_1111);
    enq(4'd10, 32'h300, 4'hF, 32'h2222_2222);
    ld_addr = 32'h300; ld_rmask = 4'hF;
    #1;
    chk("t5_hit", 32'(fwd_hit), 32'd1);
    chk("t5_data", fwd_data, 32'h2222_2222);
    apply_stimulus(0, '0, '0, '0, '0, 0, '0, 1);
    ld_rmask = 4'h0;

    // Fill to DEPTH, reject an extra store, then drain across the pointer wrap.
    resp_mode = 0;
    drained.delete();
    for (int k = 0; k < DEPTH; k++) enq(RW'(k), 32'h600 + 32'(4 * k), 4'hF, $urandom);
    enq(4'd15, 32'h640, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("t6_ready", 32'(sb_if.enq_ready), 32'd0);
    chk("t6_count", 32'(count), 32'(DEPTH));
    resp_mode = 1;
    for (int k = 0; k < DEPTH; k++) commit(RW'(k));
    drain_wait("t6_drain");
    chk("t6_n", 32'(drained.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH && k < drained.size(); k++)
      chk("t6_order", drained[k], 32'h600 + 32'(4 * k));

    // Reset while a store is in flight: a late response must be ignored.
    resp_mode = 0;
    enq(4'd3, 32'h400, 4'hF, 32'h4444_4444);
    commit(4'd3);
    idle();
    reset_dut();
    resp_mode = 3;
    idle();
    idle();
    #1;
    chk("t7_count", 32'(count), 32'd0);
    chk("t7_wmask", 32'(sb_if.dmem_wmask), 32'd0);

    // Randomized traffic against the model.
    resp_mode = 2;
    rob = '0;
    for (int n = 0; n < 600; n++) begin
      bit            ev, cv, fl;
      logic [RW-1:0] crob;
      ev = ($urandom_range(0, 1) == 1);
      a  = 32'h500 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      cv = ($urandom_range(0, 9) < 7);
      if (m_cmt < mq.size() && $urandom_range(0, 9) < 8) crob = mq[m_cmt].rob;
      else crob = RW'($urandom);
      fl = ($urandom_range(0, 24) == 0);
      ld_addr  = 32'h500 + 32'($urandom_range(0, 3)) * 4;
      ld_rmask = 4'($urandom);
      apply_stimulus(ev, rob, a, 4'($urandom_range(1, 15)), $urandom, cv, crob, fl);
      if (ev) rob = rob + 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
